// File: rtl/uart_tx_parity_if.sv
// Byte handshake between an upstream producer and the uart_tx_parity serialiser.
interface uart_tx_parity_if;
   logic       i_tx_dv;
   logic [7:0] i_tx_data;
   logic       o_tx_ready;

   modport master (output i_tx_dv, output i_tx_data, input  o_tx_ready);
   modport slave  (input  i_tx_dv, input  i_tx_data, output o_tx_ready);
endinterface

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data LSB-first, even parity, stop (8E1) at CLK_PER_BIT clocks/bit.
// Define UART_TX_PARITY_EN for the 8E1 frame; leave it undefined for a plain 8N1 frame.
module uart_tx_parity #(
   parameter int CLK_PER_BIT = 87
) (
   input  logic            clk,
   input  logic            reset,
   uart_tx_parity_if.slave tx,
   output logic            o_tx_serial,
   output logic            o_tx_active,
   output logic            o_tx_done
);

   localparam logic [15:0] LAST = 16'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t      state, state_d;
   logic [15:0] cnt, cnt_d;
   logic [2:0]  idx, idx_d;
   logic [7:0]  shift, shift_d;
   logic        serial_d, done_d;
   logic        last;
`ifdef UART_TX_PARITY_EN
   logic        par, par_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shift       <= '0;
         o_tx_serial <= 1'b1;
         o_tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par         <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         idx         <= idx_d;
         shift       <= shift_d;
         o_tx_serial <= serial_d;
         o_tx_done   <= done_d;
`ifdef UART_TX_PARITY_EN
         par         <= par_d;
`endif
      end
   end

   assign last          = (cnt == LAST);
   assign tx.o_tx_ready = (state == IDLE);
   assign o_tx_active   = (state != IDLE);

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      idx_d    = idx;
      shift_d  = shift;
      done_d   = 1'b0;
      serial_d = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d    = par;
`endif
      case (state)
         IDLE: begin
            if (tx.i_tx_dv) begin
               state_d = START;
               shift_d = tx.i_tx_data;
               cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
               par_d   = ^tx.i_tx_data;
`endif
            end
         end
         START: begin
            if (last) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt + 16'd1;
            end
         end
         DATA: begin
            if (last) begin
               cnt_d = '0;
               if (idx == 3'd7) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d   = idx + 3'd1;
                  shift_d = {1'b0, shift[7:1]};
               end
            end else begin
               cnt_d = cnt + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (last) begin
               state_d = STOP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 16'd1;
            end
         end
`endif
         STOP: begin
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // The line is registered, so drive it from the state being entered.
      case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  serial_d = par_d;
`endif
         default: serial_d = 1'b1;
      endcase
   end

endmodule
